// File: rtl/alu_apb_scheduler_if.sv
// APB3 master/slave bundle between alu_apb_scheduler and the ALU's APB slave port.
interface alu_apb_scheduler_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/alu_apb_scheduler.sv
// alu_apb_scheduler: round-robin sharing of one APB-attached ALU among NREQ
// requesters. Each granted command is written to the ALU (paddr 0), the
// scheduler idles OP_WAIT cycles, then reads the 9-bit result back from the
// slot named by the command's address field and returns it with an error flag.
//
// Build option: define ALU_SCHED_READBACK_EN to enable the read-back phase.
// Without it the FSM goes WAIT -> RESP, rsp_data is tied to 0 and rsp_err
// covers only the address check and the write phase.
module alu_apb_scheduler #(
    parameter int NREQ    = 4,
    parameter int OP_WAIT = 6,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*32-1:0]   i_cmd,
    output logic [NREQ-1:0]      o_ack,
    output logic [8:0]           o_rsp_data,
    output logic                 o_rsp_err,
    output logic                 o_alu_state,
    alu_apb_scheduler_if.master  apb
);

    localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_MAX = (OP_WAIT > TIMEOUT) ? OP_WAIT : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [PW-1:0] PTR_RST   = PW'(NREQ - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(OP_WAIT - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WSETUP,
        S_WACCESS,
        S_WAIT,
        S_RSETUP,
        S_RACCESS,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_grant;
    logic [PW-1:0]   w_grant;
    logic [PW-1:0]   w_idx;
    logic            w_found;
    logic [31:0]     r_cmd;
    logic [31:0]     w_grant_cmd;
    logic            w_bad_addr;
    logic [CW-1:0]   r_cnt;
    logic            w_timeout;
    logic            r_err;
    logic            w_err_next;
    logic            r_rsp_err;
    logic            w_unused;

    // Round-robin search starting just after the last grant; walking the
    // offsets downwards lets the nearest requester win without a break.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_ptr;
        w_idx   = '0;
        for (int off = NREQ; off >= 1; off--) begin
            w_idx = PW'((int'(r_ptr) + off) % NREQ);
            if (i_req[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // Select the candidate's command word so ARB can check and latch it.
    always_comb begin
        w_grant_cmd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == PW'(i)) begin
                w_grant_cmd = i_cmd[32*i +: 32];
            end
        end
    end

    // Only result slots 0..15 exist in the ALU.
    assign w_bad_addr = (w_grant_cmd[5:0] > 6'd15);
    assign w_timeout  = (r_cnt == TO_LAST) && !apb.pready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (|i_req) w_next_state = S_ARB;
            S_ARB: begin
                if (!w_found)        w_next_state = S_IDLE;
                else if (w_bad_addr) w_next_state = S_RESP;
                else                 w_next_state = S_WSETUP;
            end
            S_WSETUP:  w_next_state = S_WACCESS;
            S_WACCESS: begin
                if (apb.pready)     w_next_state = S_WAIT;
                else if (w_timeout) w_next_state = S_RESP;
            end
            S_WAIT: begin
                if (r_cnt == WAIT_LAST) begin
`ifdef ALU_SCHED_READBACK_EN
                    w_next_state = S_RSETUP;
`else
                    w_next_state = S_RESP;
`endif
                end
            end
            S_RSETUP:  w_next_state = S_RACCESS;
            S_RACCESS: if (apb.pready || w_timeout) w_next_state = S_RESP;
            S_RESP:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Error accumulation: seeded by the address check, OR-ed with pslverr on
    // each completed transfer, forced on an ACCESS timeout.
    always_comb begin
        w_err_next = r_err;
        case (r_state)
            S_ARB: w_err_next = w_bad_addr;
            S_WACCESS, S_RACCESS: begin
                if (apb.pready)     w_err_next = r_err | apb.pslverr;
                else if (w_timeout) w_err_next = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers: grant pointer, latched command, cycle counter and
    // the response error flag that holds between acks.
    // NOTE: control and datapath flops are all reset so a reset mid-transaction
    // leaves no stale grant, command or error behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr     <= PTR_RST;
            r_grant   <= '0;
            r_cmd     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
            // Cleared on every state change, so each ACCESS/WAIT starts at 0.
            r_cnt <= (w_next_state != r_state) ? '0 : r_cnt + 1'b1;
            if (r_state == S_ARB && w_found) begin
                r_grant <= w_grant;
                r_ptr   <= w_grant;
                r_cmd   <= w_grant_cmd;
            end
            if (w_next_state == S_RESP && r_state != S_RESP) begin
                r_rsp_err <= w_err_next;
            end
        end
    end

`ifdef ALU_SCHED_READBACK_EN
    logic [8:0] r_rsp_data;

    // Capture the ALU result on the completing read transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_data <= '0;
        end else if (r_state == S_RACCESS && apb.pready) begin
            r_rsp_data <= apb.prdata[8:0];
        end
    end

    assign o_rsp_data = r_rsp_data;
    assign w_unused   = ^apb.prdata[31:9];
`else
    assign o_rsp_data = '0;
    assign w_unused   = ^apb.prdata;
`endif

    assign o_rsp_err = r_rsp_err;

    // Moore outputs: APB controls, ALU state strobe and the ack pulse.
    always_comb begin
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;
        o_alu_state = 1'b0;
        o_ack       = '0;
        case (r_state)
            S_WSETUP, S_WACCESS: begin
                apb.psel    = 1'b1;
                apb.penable = (r_state == S_WACCESS);
                apb.pwrite  = 1'b1;
                apb.pwdata  = r_cmd;
                o_alu_state = 1'b1;
            end
            S_WAIT: o_alu_state = 1'b1;
            S_RSETUP, S_RACCESS: begin
                apb.psel    = 1'b1;
                apb.penable = (r_state == S_RACCESS);
                apb.paddr   = {26'b0, r_cmd[5:0]};
                o_alu_state = 1'b1;
            end
            S_RESP: o_ack[r_grant] = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_apb_scheduler.sv
// Self-checking bench for alu_apb_scheduler. Follows ALU_SCHED_READBACK_EN
// the same way the design does.
module tb_alu_apb_scheduler;
    localparam int NREQ    = 4;
    localparam int OP_WAIT = 6;
    localparam int TIMEOUT = 16;
    localparam int HANG    = 1000;
    localparam int LIMIT   = 200;
`ifdef ALU_SCHED_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     i_req;
    logic [NREQ*32-1:0]  i_cmd;
    logic [NREQ-1:0]     o_ack;
    logic [8:0]          o_rsp_data;
    logic                o_rsp_err;
    logic                o_alu_state;

    alu_apb_scheduler_if apb ();

    alu_apb_scheduler #(.NREQ(NREQ), .OP_WAIT(OP_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_req       (i_req),
        .i_cmd       (i_cmd),
        .o_ack       (o_ack),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_err   (o_rsp_err),
        .o_alu_state (o_alu_state),
        .apb         (apb)
    );

    always #5 clk = ~clk;

    // APB slave model with programmable wait states, error and read data.
    int          slv_wait_w, slv_wait_r;
    bit          slv_err_w, slv_err_r;
    logic [31:0] slv_rdata;
    int          acc_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                        acc_cnt <= 0;
        else if (apb.psel && apb.penable && !apb.pready)     acc_cnt <= acc_cnt + 1;
        else                                                 acc_cnt <= 0;
    end

    assign apb.pready  = apb.psel && apb.penable &&
                         (acc_cnt >= (apb.pwrite ? slv_wait_w : slv_wait_r));
    assign apb.pslverr = apb.pready && (apb.pwrite ? slv_err_w : slv_err_r);
    assign apb.prdata  = slv_rdata;

    // Transfer monitor and protocol watch.
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t xq[$];
    int    viol = 0;

    always @(negedge clk) begin
        xfer_t x;
        if (apb.penable && !apb.psel) viol <= viol + 1;
        if (apb.psel && apb.penable && apb.pready) begin
            x.wr   = apb.pwrite;
            x.addr = apb.paddr;
            x.data = apb.pwdata;
            xq.push_back(x);
        end
    end

    // Reference model state.
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_ptr;
    logic [8:0]  m_data;
    logic [31:0] cmd_arr [NREQ];

    function automatic int model_grant(input logic [NREQ-1:0] m);
        for (int off = 1; off <= NREQ; off++) begin
            if (m[(m_ptr + off) % NREQ]) return (m_ptr + off) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_cmd(input int max_addr);
        logic [31:0] c;
        c      = $urandom;
        c[5:0] = 6'($urandom_range(0, max_addr));
        return c;
    endfunction

    task automatic drive_cmds();
        for (int i = 0; i < NREQ; i++) i_cmd[32*i +: 32] = cmd_arr[i];
    endtask

    // One transaction from idle: predicts grant, latency, response and the
    // APB transfers from the behavioural rules, then compares.
    task automatic run_txn(input string name, input logic [NREQ-1:0] mask,
                           input int ww, input int rw, input bit ew, input bit er,
                           input logic [31:0] rdata);
        int g, n_exp, n_got, psel_cnt, alu_cnt, exp_psel, exp_nx;
        bit bad, wto, do_read, rto, exp_err, err_got;
        logic [8:0] exp_data, data_got;
        logic [31:0] c;
        logic [NREQ-1:0] exp_ack, ack_got;

        g       = model_grant(mask);
        m_ptr   = g;
        c       = cmd_arr[g];
        bad     = (c[5:0] > 6'd15);
        wto     = !bad && (ww >= TIMEOUT);
        do_read = READBACK && !bad && !wto;
        rto     = do_read && (rw >= TIMEOUT);
        if (bad)      n_exp = 2;
        else if (wto) n_exp = TIMEOUT + 3;
        else begin
            n_exp = 2 + (ww + 1) + OP_WAIT + 1;
            if (do_read) n_exp += 1 + (rto ? TIMEOUT : rw + 1);
        end
        exp_err  = bad || wto || ew || (do_read && (rto || er));
        exp_data = !READBACK ? 9'd0 : (do_read && !rto) ? rdata[8:0] : m_data;
        exp_ack  = '0;
        exp_ack[g] = 1'b1;
        exp_psel = bad ? 0 : wto ? n_exp - 2 : n_exp - 2 - OP_WAIT;
        exp_nx   = (bad || wto) ? 0 : (do_read && !rto) ? 2 : 1;

        slv_wait_w = ww; slv_wait_r = rw;
        slv_err_w  = ew; slv_err_r  = er;
        slv_rdata  = rdata;
        drive_cmds();
        xq.delete();
        i_req = mask;
        n_got = 0; psel_cnt = 0; alu_cnt = 0;
        ack_got = '0; data_got = '0; err_got = 1'b0;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            // Command is latched in ARB; scrambling it afterwards must not matter.
            if (k == 2) i_cmd = ~i_cmd;
            psel_cnt += int'(apb.psel);
            alu_cnt  += int'(o_alu_state);
            if (o_ack != '0) begin
                n_got = k; ack_got = o_ack; data_got = o_rsp_data; err_got = o_rsp_err;
                break;
            end
        end
        i_req = '0;

        n_checks++;
        if (n_got == 0) begin
            n_fail++; $display("FAIL %s ack_timeout: no ack within %0d cycles, expected at %0d", name, LIMIT, n_exp);
        end else begin
            n_checks++;
            if (ack_got !== exp_ack) begin n_fail++; $display("FAIL %s ack: got %b expected %b", name, ack_got, exp_ack); end
            n_checks++;
            if (n_got != n_exp) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, n_got, n_exp); end
            n_checks++;
            if (err_got !== exp_err) begin n_fail++; $display("FAIL %s rsp_err: got %b expected %b", name, err_got, exp_err); end
            n_checks++;
            if (data_got !== exp_data) begin n_fail++; $display("FAIL %s rsp_data: got %0d expected %0d", name, data_got, exp_data); end
            n_checks++;
            if (psel_cnt != exp_psel) begin n_fail++; $display("FAIL %s psel_cycles: got %0d expected %0d", name, psel_cnt, exp_psel); end
            n_checks++;
            if (alu_cnt != (bad ? 0 : n_exp - 2)) begin n_fail++; $display("FAIL %s alu_state_cycles: got %0d expected %0d", name, alu_cnt, bad ? 0 : n_exp - 2); end
        end
        @(negedge clk);
        n_checks++;
        if (o_ack !== '0) begin n_fail++; $display("FAIL %s ack_pulse: got %b expected 0", name, o_ack); end
        n_checks++;
        if (xq.size() != exp_nx) begin
            n_fail++; $display("FAIL %s xfer_count: got %0d expected %0d", name, xq.size(), exp_nx);
        end else begin
            if (exp_nx >= 1) begin
                n_checks++;
                if (xq[0].wr !== 1'b1 || xq[0].addr !== 32'd0 || xq[0].data !== c) begin
                    n_fail++; $display("FAIL %s write_xfer: got wr=%b addr=%h data=%h expected wr=1 addr=0 data=%h", name, xq[0].wr, xq[0].addr, xq[0].data, c);
                end
            end
            if (exp_nx == 2) begin
                n_checks++;
                if (xq[1].wr !== 1'b0 || xq[1].addr !== {26'b0, c[5:0]}) begin
                    n_fail++; $display("FAIL %s read_xfer: got wr=%b addr=%h expected wr=0 addr=%h", name, xq[1].wr, xq[1].addr, {26'b0, c[5:0]});
                end
            end
        end
        m_data = exp_data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== '0) begin
            n_fail++; $display("FAIL reset apb: got psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h expected all 0", apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata);
        end
        n_checks++;
        if ({o_ack, o_rsp_data, o_rsp_err, o_alu_state} !== '0) begin
            n_fail++; $display("FAIL reset outputs: got ack=%b data=%0d err=%b alu_state=%b expected all 0", o_ack, o_rsp_data, o_rsp_err, o_alu_state);
        end
        reset_n = 1'b1;
        m_ptr   = NREQ - 1;
        m_data  = '0;
        @(negedge clk);
    endtask

    task automatic test_single();
        cmd_arr[0] = 32'h1000C142;
        run_txn("t1_single", 4'b0001, 0, 0, 1'b0, 1'b0, 32'd8);
        cmd_arr[3] = rand_cmd(15);
        run_txn("t1_waits", 4'b1000, 2, 3, 1'b0, 1'b0, $urandom);
    endtask

    task automatic test_bad_addr();
        cmd_arr[1] = 32'h1000C154;
        run_txn("t3_bad_addr", 4'b0010, 0, 0, 1'b0, 1'b0, $urandom);
    endtask

    task automatic test_timeout();
        cmd_arr[2] = rand_cmd(15);
        run_txn("t4_write_timeout", 4'b0100, HANG, 0, 1'b0, 1'b0, $urandom);
        cmd_arr[0] = rand_cmd(15);
        run_txn("t4_read_timeout", 4'b0001, 0, HANG, 1'b0, 1'b0, $urandom);
    endtask

    task automatic test_slverr();
        cmd_arr[1] = rand_cmd(15);
        run_txn("t4_read_slverr", 4'b0010, 0, 0, 1'b0, 1'b1, 32'h0000_01A5);
        cmd_arr[2] = rand_cmd(15);
        run_txn("t4_write_slverr", 4'b0100, 1, 0, 1'b1, 1'b0, 32'h0000_0077);
    endtask

    task automatic test_reset_mid_txn();
        int acks;
        for (int i = 0; i < NREQ; i++) cmd_arr[i] = rand_cmd(15);
        cmd_arr[2] = 32'h1000C142;
        drive_cmds();
        slv_wait_w = 0; slv_wait_r = 0; slv_err_w = 0; slv_err_r = 0;
        slv_rdata  = 32'h0000_0155;
        i_req = 4'b1100;
        acks  = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (o_ack != '0) acks++;
        end
        n_checks++;
        if (acks != 0) begin n_fail++; $display("FAIL t5_early_ack: got %0d acks expected 0", acks); end
        reset_n = 1'b0;
        i_req   = '0;
        #1;
        n_checks++;
        if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== '0) begin
            n_fail++; $display("FAIL t5_reset_apb: got psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h expected all 0", apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata);
        end
        n_checks++;
        if ({o_ack, o_rsp_data, o_rsp_err, o_alu_state} !== '0) begin
            n_fail++; $display("FAIL t5_reset_outputs: got ack=%b data=%0d err=%b alu_state=%b expected all 0", o_ack, o_rsp_data, o_rsp_err, o_alu_state);
        end
        m_ptr  = NREQ - 1;
        m_data = '0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_txn("t5_after_reset", 4'b1100, 0, 0, 1'b0, 1'b0, 32'h0000_0155);
    endtask

    task automatic test_back_to_back();
        int n0, k, prev, g, n_got;
        int grants [5];
        logic [NREQ-1:0] exp_ack;
        logic [31:0] rdata;

        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_ptr  = NREQ - 1;
        m_data = '0;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) cmd_arr[i] = rand_cmd(15);
        drive_cmds();
        rdata = $urandom;
        slv_wait_w = 0; slv_wait_r = 0; slv_err_w = 0; slv_err_r = 0;
        slv_rdata  = rdata;
        n0 = READBACK ? OP_WAIT + 6 : OP_WAIT + 4;
        xq.delete();
        i_req = 4'b1111;
        k = 0; prev = 0;
        for (int t = 0; t < 5; t++) begin
            g = model_grant(4'b1111);
            m_ptr = g;
            grants[t] = g;
            exp_ack = '0;
            exp_ack[g] = 1'b1;
            n_got = 0;
            for (int j = 0; j < LIMIT; j++) begin
                @(negedge clk);
                k++;
                if (o_ack != '0) begin n_got = k; break; end
            end
            n_checks++;
            if (n_got == 0) begin
                n_fail++; $display("FAIL t2_ack_timeout[%0d]: no ack within %0d cycles", t, LIMIT);
            end else begin
                n_checks++;
                if (o_ack !== exp_ack) begin n_fail++; $display("FAIL t2_grant[%0d]: got %b expected %b", t, o_ack, exp_ack); end
                n_checks++;
                if ((n_got - prev) != (t == 0 ? n0 : n0 + 1)) begin
                    n_fail++; $display("FAIL t2_spacing[%0d]: got %0d expected %0d", t, n_got - prev, t == 0 ? n0 : n0 + 1);
                end
                n_checks++;
                if (o_rsp_data !== (READBACK ? rdata[8:0] : 9'd0) || o_rsp_err !== 1'b0) begin
                    n_fail++; $display("FAIL t2_rsp[%0d]: got data=%0d err=%b expected data=%0d err=0", t, o_rsp_data, o_rsp_err, READBACK ? rdata[8:0] : 9'd0);
                end
            end
            prev = n_got;
        end
        i_req = '0;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (xq.size() != 5 * (READBACK ? 2 : 1)) begin
            n_fail++; $display("FAIL t2_xfer_count: got %0d expected %0d", xq.size(), 5 * (READBACK ? 2 : 1));
        end else begin
            for (int t = 0; t < 5; t++) begin
                n_checks++;
                if (xq[t * (READBACK ? 2 : 1)].data !== cmd_arr[grants[t]]) begin
                    n_fail++; $display("FAIL t2_write_data[%0d]: got %h expected %h", t, xq[t * (READBACK ? 2 : 1)].data, cmd_arr[grants[t]]);
                end
            end
        end
        m_data = READBACK ? rdata[8:0] : 9'd0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [NREQ-1:0] mask;
            int ww, rw;
            for (int i = 0; i < NREQ; i++) cmd_arr[i] = rand_cmd(19);
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            ww   = ($urandom_range(0, 9) == 0) ? HANG : $urandom_range(0, 3);
            rw   = ($urandom_range(0, 9) == 0) ? HANG : $urandom_range(0, 3);
            run_txn($sformatf("random%0d", n), mask, ww, rw,
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), $urandom);
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL protocol penable_without_psel: got %0d cycles expected 0", viol); end
    endtask

    initial begin
        reset_n = 1'b0;
        i_req   = '0;
        i_cmd   = '0;
        slv_wait_w = 0; slv_wait_r = 0; slv_err_w = 0; slv_err_r = 0;
        slv_rdata  = '0;
        for (int i = 0; i < NREQ; i++) cmd_arr[i] = '0;
        m_ptr  = NREQ - 1;
        m_data = '0;

        test_reset();
        test_single();
        test_bad_addr();
        test_timeout();
        test_slverr();
        test_reset_mid_txn();
        test_back_to_back();
        test_random();
        test_protocol();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
